// File: rtl/bcd_disp_pkg.sv
// rtl/bcd_disp_pkg.sv - shared types and constants for the BCD display driver
// Purpose: FSM state encoding, digit/segment constants and the double-dabble
//          nibble adjust helper used by bcd_disp_drv and seg7_decode.
// Ports:   none (package).
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CONV_BITS = 7;

  localparam logic [3:0] DIGIT_DASH = 4'hF;

  // Active-high segment patterns, bit order {a,b,c,d,e,f,g}
  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Double-dabble correction: a nibble >= 5 would exceed 9 after the shift
  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

endpackage

// File: rtl/bcd_disp_seg7_decode.sv
// rtl/bcd_disp_seg7_decode.sv - BCD digit to seven-segment pattern decoder
// Purpose: combinational decode of one digit into active-high segments.
// Ports:   digit [3:0] in  - BCD digit, 4'hF selects the dash pattern
//          blank       in  - force all segments off
//          seg   [6:0] out - {a,b,c,d,e,f,g}, active-high
module seg7_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:       seg = SEG_0;
        4'd1:       seg = SEG_1;
        4'd2:       seg = SEG_2;
        4'd3:       seg = SEG_3;
        4'd4:       seg = SEG_4;
        4'd5:       seg = SEG_5;
        4'd6:       seg = SEG_6;
        4'd7:       seg = SEG_7;
        4'd8:       seg = SEG_8;
        4'd9:       seg = SEG_9;
        DIGIT_DASH: seg = SEG_DASH;
        default:    seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/bcd_disp_drv.sv
// rtl/bcd_disp_drv.sv - binary 0..99 to 2-digit multiplexed seven-segment driver
// Purpose: synchronise bin_in, convert to BCD with a shift-add-3 FSM and scan
//          the two digits onto a common-anode display.
// Ports:   CLK, RST    in  - board clock, async active-high reset
//          bin_in [6:0] in - binary count
//          tens, ones  out - BCD digits (4'hF each on overflow)
//          ovf         out - last converted value was above 99
//          busy        out - conversion in progress
//          seg [6:0]   out - segments {a..g}, registered
//          an [1:0]    out - digit enables (an[1]=tens), registered
module bcd_disp_drv
  import bcd_disp_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] bin_in,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       ovf,
  output logic       busy,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0] AN_OFF  = (SEG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  state_t      r_state, w_state_n;
  logic [6:0]  r_s_in;
  logic [6:0]  r_last, w_last_n;
  logic [14:0] r_sh, w_sh_n;
  logic [2:0]  r_bit_cnt, w_bit_cnt_n;
  logic [3:0]  r_tens, w_tens_n;
  logic [3:0]  r_ones, w_ones_n;
  logic        r_ovf, w_ovf_n;
  logic        r_busy, w_busy_n;
  logic [14:0] w_adj;

  logic [15:0] r_scan_cnt;
  logic        r_digit_sel;
  logic [3:0]  w_digit;
  logic        w_blank;
  logic [6:0]  w_seg_hi;
  logic [6:0]  r_seg;
  logic [1:0]  r_an;

  assign tens = r_tens;
  assign ones = r_ones;
  assign ovf  = r_ovf;
  assign busy = r_busy;
  assign seg  = r_seg;
  assign an   = r_an;

  // Adjust both BCD nibbles before the shift
  assign w_adj = {add3(r_sh[14:11]), add3(r_sh[10:7]), r_sh[6:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= IDLE;
      r_s_in    <= 7'd0;
      r_last    <= 7'd0;
      r_sh      <= 15'd0;
      r_bit_cnt <= 3'd0;
      r_tens    <= 4'd0;
      r_ones    <= 4'd0;
      r_ovf     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_s_in    <= bin_in;
      r_last    <= w_last_n;
      r_sh      <= w_sh_n;
      r_bit_cnt <= w_bit_cnt_n;
      r_tens    <= w_tens_n;
      r_ones    <= w_ones_n;
      r_ovf     <= w_ovf_n;
      r_busy    <= w_busy_n;
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_last_n    = r_last;
    w_sh_n      = r_sh;
    w_bit_cnt_n = r_bit_cnt;
    w_tens_n    = r_tens;
    w_ones_n    = r_ones;
    w_ovf_n     = r_ovf;
    w_busy_n    = r_busy;
    case (r_state)
      IDLE: begin
        if (r_s_in != r_last) begin
          w_sh_n      = {8'h00, r_s_in};
          w_last_n    = r_s_in;
          w_bit_cnt_n = 3'd0;
          w_busy_n    = 1'b1;
          w_state_n   = CONV;
        end
      end
      CONV: begin
        w_sh_n      = {w_adj[13:0], 1'b0};
        w_bit_cnt_n = r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'(CONV_BITS - 1)) begin
          w_state_n = DONE;
        end
      end
      DONE: begin
        // Outputs change only here, so they never show a partial result
        if (r_last > 7'd99) begin
          w_tens_n = DIGIT_DASH;
          w_ones_n = DIGIT_DASH;
          w_ovf_n  = 1'b1;
        end else begin
          w_tens_n = r_sh[14:11];
          w_ones_n = r_sh[10:7];
          w_ovf_n  = 1'b0;
        end
        w_busy_n  = 1'b0;
        w_state_n = IDLE;
      end
      default: begin
        w_state_n = IDLE;
        w_busy_n  = 1'b0;
      end
    endcase
  end

  // Digit scan, free-running and independent of the converter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_scan_cnt  <= 16'd0;
      r_digit_sel <= 1'b0;
    end else if (r_scan_cnt == 16'(SCAN_DIV - 1)) begin
      r_scan_cnt  <= 16'd0;
      r_digit_sel <= ~r_digit_sel;
    end else begin
      r_scan_cnt  <= r_scan_cnt + 16'd1;
    end
  end

  assign w_digit = r_digit_sel ? r_tens : r_ones;
  // Leading-zero blanking applies only to the tens position
  assign w_blank = r_digit_sel && (r_tens == 4'd0) && !r_ovf;

  seg7_decode u_seg7_decode (
    .digit (w_digit),
    .blank (w_blank),
    .seg   (w_seg_hi)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_seg <= SEG_OFF;
      r_an  <= AN_OFF;
    end else begin
      r_seg <= (SEG_ACTIVE_LOW != 0) ? ~w_seg_hi : w_seg_hi;
      r_an  <= (SEG_ACTIVE_LOW != 0) ? ~(r_digit_sel ? 2'b10 : 2'b01)
                                     :  (r_digit_sel ? 2'b10 : 2'b01);
    end
  end

endmodule

// File: tb/tb_bcd_disp_drv.sv
// tb/tb_bcd_disp_drv.sv - scoreboard testbench for bcd_disp_drv
module tb_bcd_disp_drv;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [6:0] bin_in = 7'd0;
  logic [3:0] tens, ones;
  logic       ovf, busy;
  logic [6:0] seg;
  logic [1:0] an;

  always #5 CLK = ~CLK;

  bcd_disp_drv #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1)) dut (
    .CLK    (CLK),
    .RST    (RST),
    .bin_in (bin_in),
    .tens   (tens),
    .ones   (ones),
    .ovf    (ovf),
    .busy   (busy),
    .seg    (seg),
    .an     (an)
  );

  typedef struct packed {
    logic [3:0] t;
    logic [3:0] o;
    logic       v;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: result registers may only change when busy falls
  logic prev_busy = 1'b0;
  logic [8:0] prev_out = 9'd0;
  exp_t mon_e;
  always @(negedge CLK) begin
    if (RST) begin
      prev_busy = busy;
      prev_out  = {tens, ones, ovf};
    end else begin
      if (prev_busy && !busy) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_result actual=%0h required=none", {tens, ones, ovf});
        end else begin
          mon_e = sb_q.pop_front();
          check("sb_result{tens,ones,ovf}", {23'd0, tens, ones, ovf}, {23'd0, mon_e});
        end
      end else if ({tens, ones, ovf} != prev_out) begin
        checks++;
        errors++;
        $display("FAIL out_change_without_done actual=%0h required=%0h", {tens, ones, ovf}, prev_out);
      end
      prev_busy = busy;
      prev_out  = {tens, ones, ovf};
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_busy(input logic lvl, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge CLK);
      if (busy === lvl) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_an(input logic [1:0] v);
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (an === v) break;
    end
  endtask

  task automatic check_slots(input string name, input logic [6:0] ones_seg, input logic [6:0] tens_seg);
    cyc(1);
    wait_an(2'b10);
    check({name, "_an_ones"}, an, 2'b10);
    check({name, "_seg_ones"}, seg, ones_seg);
    wait_an(2'b01);
    check({name, "_an_tens"}, an, 2'b01);
    check({name, "_seg_tens"}, seg, tens_seg);
  endtask

  task automatic drive(input logic [6:0] v, input exp_t e);
    @(negedge CLK);
    bin_in = v;
    sb_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1);
  end

  int n, n1, n2;

  initial begin
    // 1: reset state and idle scan with blanking
    #1 RST = 1'b1;
    #1;
    check("t1_rst_tens", tens, 4'd0);
    check("t1_rst_ones", ones, 4'd0);
    check("t1_rst_ovf", ovf, 1'b0);
    check("t1_rst_busy", busy, 1'b0);
    cyc(2);
    RST = 1'b0;
    check_slots("t1", 7'b0000001, 7'b1111111);

    // 2: 57 with exact latency
    drive(7'd57, exp_t'{4'd5, 4'd7, 1'b0});
    wait_busy(1'b1, 20, n);
    check("t2_busy_rise_cycles", n, 2);
    wait_busy(1'b0, 20, n);
    check("t2_busy_high_cycles", n, 8);
    check_slots("t2", 7'b0001111, 7'b0100100);

    // 3: sweep 0..99
    for (int v = 0; v < 100; v++) begin
      drive(7'(v), exp_t'{4'(v / 10), 4'(v % 10), 1'b0});
      cyc(11);
    end
    check("t3_99", {tens, ones, ovf}, {4'd9, 4'd9, 1'b0});

    // 4: overflow then recovery
    drive(7'd100, exp_t'{4'hF, 4'hF, 1'b1});
    cyc(11);
    check("t4_ovf_100", {tens, ones, ovf}, {4'hF, 4'hF, 1'b1});
    check_slots("t4_dash", 7'b1111110, 7'b1111110);
    drive(7'd127, exp_t'{4'hF, 4'hF, 1'b1});
    cyc(11);
    drive(7'd42, exp_t'{4'd4, 4'd2, 1'b0});
    cyc(11);
    check("t4_42", {tens, ones, ovf}, {4'd4, 4'd2, 1'b0});

    // 5: input change mid-conversion, back-to-back conversions
    drive(7'd23, exp_t'{4'd2, 4'd3, 1'b0});
    wait_busy(1'b1, 20, n);
    cyc(2);
    bin_in = 7'd81;
    sb_q.push_back(exp_t'{4'd8, 4'd1, 1'b0});
    wait_busy(1'b0, 20, n);
    @(negedge CLK);
    check("t5_second_busy_next_cycle", busy, 1'b1);
    wait_busy(1'b0, 20, n);
    cyc(2);

    // 6: reset mid-conversion, then reconversion
    @(negedge CLK);
    bin_in = 7'd64;
    wait_busy(1'b1, 20, n);
    cyc(3);
    #2 RST = 1'b1;
    #1;
    check("t6_rst_tens", tens, 4'd0);
    check("t6_rst_ones", ones, 4'd0);
    check("t6_rst_ovf", ovf, 1'b0);
    check("t6_rst_busy", busy, 1'b0);
    cyc(2);
    sb_q.push_back(exp_t'{4'd6, 4'd4, 1'b0});
    RST = 1'b0;
    wait_busy(1'b1, 11, n1);
    wait_busy(1'b0, 11, n2);
    check("t6_reconv_within_11", (n1 > 0 && n2 > 0 && (n1 + n2) <= 11), 1);
    cyc(2);
    check("t6_64", {tens, ones, ovf}, {4'd6, 4'd4, 1'b0});

    check("sb_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
